regbank_write_arbiter: RTL and testbench
========================================

Name: regbank_write_arbiter

Overview:
- Owns the single write port (we3/wa3/wd3) of the 32x32 register bank and shares it between NREQ requesters.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- After reset or a clear command, runs a zero-fill sweep over every register before accepting any request.
- Sits between the datapath write sources (ALU writeback, load unit, debug port, …) and the register bank write port.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 5, register address width; bank depth is 2**AW
DW, 32, data width
ZERO_REG_RO, 1, when 1, register 0 is read-only: writes to address 0 are accepted but never reach the bank

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
clear  input  1  synchronous request to re-run the zero-fill sweep
req_valid  input  NREQ  per-requester write request
req_ready  output  NREQ  per-requester grant; a transfer occurs when valid and ready are both high at a rising edge
req_addr  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
req_data  input  NREQ*DW  packed data; requester i uses bits [i*DW +: DW]
we3  output  1  bank write enable (registered)
wa3  output  AW  bank write address (registered)
wd3  output  DW  bank write data (registered)
grant_id  output  clog2(NREQ)  index of the requester whose write is on we3/wa3/wd3 (registered)
init_done  output  1  high while in RUN state (registered)

Behaviour:
- Reset (async, rst=1):
  - we3=0, wa3=0, wd3=0, grant_id=0, init_done=0.
  - state=INIT, sweep counter=0, round-robin pointer=0.
  - Any accepted-but-not-yet-driven write is discarded.
- FSM has two states: INIT and RUN.
- INIT:
  - req_ready=0 for every requester.
  - Each edge registers we3=1, wa3=cnt, wd3=0, then cnt++.
  - The edge that registers wa3=2**AW-1 also sets state=RUN and init_done=1.
  - The sweep takes exactly 2**AW edges after rst deasserts (32 by default).
- RUN, arbitration:
  - req_ready is combinational.
  - Scan starts at ptr and wraps (ptr, ptr+1, …, NREQ-1, 0, …).
  - The first requester with req_valid=1 gets req_ready=1; all others get 0. At most one ready is high per cycle.
- RUN, on a transfer by requester i at an edge:
  - wa3=addr_i, wd3=data_i, grant_id=i are registered.
  - we3=1, except we3=0 when ZERO_REG_RO=1 and addr_i=0.
  - ptr=(i+1) mod NREQ.
  - Latency: handshake edge to write visible on bank outputs is 1 cycle; the bank commits on the following edge.
- RUN, no transfer: we3=0; wa3/wd3/grant_id hold; ptr holds.
- Throughput is one write per cycle; back-to-back grants are allowed, including to the same requester when it is the only one valid.
- Requester rules:
  - Must hold valid, addr and data stable until ready.
  - May deassert valid only after the transfer.
  - The arbiter never drops a pending valid.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,2,…,NREQ-1,0,… No requester waits more than NREQ-1 cycles.
- Same-address requests from two requesters in one cycle:
  - Each is granted in its own cycle in round-robin order.
  - The later write wins in the bank.
- clear:
  - Sampled each edge; takes priority over requests. While clear=1, req_ready=0.
  - The edge sampling clear=1 sets state=INIT, cnt=0, init_done=0, we3=0. The sweep starts on the next edge.
  - clear during INIT restarts the sweep at 0.
- Reset mid-sweep or mid-run: outputs clear immediately (no clock needed), and the sweep restarts from address 0 after rst deasserts.
- The arbiter is deterministic: no X may be propagated on we3/req_ready while req_valid is known.

Test Plan:
1. Assert rst, then release → we3=1 on edges 1..32 with wa3=0..31 and wd3=0; init_done rises with wa3=31; edge 33 gives we3=0; all req_ready=0 during the sweep.
2. After init, only requester 2 valid with addr=5, data=0xDEADBEEF → req_ready=4'b0100 the same cycle; next edge: we3=1, wa3=5, wd3=0xDEADBEEF, grant_id=2; one edge later, bank rd1 with ra1=5 reads 0xDEADBEEF.
3. All 4 requesters valid continuously with addr=i+1, data=0x11*(i+1) → grant_id sequence 0,1,2,3,0 on consecutive edges; wa3 sequence 1,2,3,4,1; we3 held high.
4. Requester 1 writes addr=0, data=0xFFFFFFFF with ZERO_REG_RO=1 → req_ready[1]=1 and the transfer completes; we3 stays 0; register 0 reads 0; ptr advances to 2.
5. Requesters 0 and 3 both write addr=7 (0xAAAA0000 and 0x0000BBBB) in the same cycle with ptr=3 → requester 3 is granted first, then 0; register 7 finally reads 0xAAAA0000.
6. Pulse clear mid-run while requester 0 is valid → req_ready=0, init_done falls, a 32-write zero sweep follows, the pending request is granted right after init_done rises; assert rst mid-sweep → we3=0 immediately and the sweep restarts at wa3=0.

Source files
------------

// File: rtl/regbank_write_arbiter.sv
// Round-robin owner of the register bank write port; zero-fills the whole bank after reset/clear.
// One-cycle handshake-to-we3 latency, one write per cycle; req_ready is low during the sweep and while clear is high.
module regbank_write_arbiter #(
  parameter int NREQ        = 4,
  parameter int AW          = 5,
  parameter int DW          = 32,
  parameter int ZERO_REG_RO = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic                     we3,
  output logic [AW-1:0]            wa3,
  output logic [DW-1:0]            wd3,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     init_done
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic            we3_q, we3_d;
  logic [AW-1:0]   wa3_q, wa3_d;
  logic [DW-1:0]   wd3_q, wd3_d;
  logic [GW-1:0]   gid_q, gid_d;
  logic            done_q, done_d;

  logic            found;
  logic [GW-1:0]   gnt;
  logic [GW:0]     sum;
  logic [AW-1:0]   gnt_addr;

  // Scan from ptr upward with wrap; first valid requester wins.
  always_comb begin
    found     = 1'b0;
    gnt       = '0;
    sum       = '0;
    req_ready = '0;
    if (state_q == RUN && !clear) begin
      for (int k = 0; k < NREQ; k++) begin
        sum = {1'b0, ptr_q} + (GW+1)'(k);
        if (sum >= (GW+1)'(NREQ)) sum = sum - (GW+1)'(NREQ);
        if (!found && req_valid[sum[GW-1:0]]) begin
          found = 1'b1;
          gnt   = sum[GW-1:0];
        end
      end
      if (found) req_ready[gnt] = 1'b1;
    end
  end

  assign gnt_addr = req_addr[gnt*AW +: AW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we3_d   = 1'b0;
    wa3_d   = wa3_q;
    wd3_d   = wd3_q;
    gid_d   = gid_q;
    done_d  = done_q;
    if (clear) begin
      state_d = INIT;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else if (state_q == INIT) begin
      we3_d = 1'b1;
      wa3_d = cnt_q;
      wd3_d = '0;
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == {AW{1'b1}}) begin
        state_d = RUN;
        done_d  = 1'b1;
      end
    end else if (found) begin
      wa3_d = gnt_addr;
      wd3_d = req_data[gnt*DW +: DW];
      gid_d = gnt;
      // Writes to r0 complete the handshake but are suppressed at the bank.
      we3_d = !((ZERO_REG_RO != 0) && (gnt_addr == '0));
      ptr_d = (gnt == GW'(NREQ-1)) ? '0 : gnt + GW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
      gid_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we3_q   <= we3_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
      gid_q   <= gid_d;
      done_q  <= done_d;
    end
  end

  assign we3       = we3_q;
  assign wa3       = wa3_q;
  assign wd3       = wd3_q;
  assign grant_id  = gid_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed plus randomized bench for regbank_write_arbiter against a cycle-level reference model.
module tb_regbank_write_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              we3;
  logic [AW-1:0]     wa3;
  logic [DW-1:0]     wd3;
  logic [1:0]        grant_id;
  logic              init_done;

  int checks = 0;
  int errors = 0;

  bit          v [NREQ];
  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] d [NREQ];
  int          waitc [NREQ];

  // Reference model state
  bit          m_run;
  int          m_cnt;
  int          m_ptr;
  logic        m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  int          m_gid;
  logic        m_done;
  logic [DW-1:0] exp_bank [DEPTH];
  logic [DW-1:0] obs_bank [DEPTH];

  regbank_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_REG_RO(1)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .grant_id(grant_id), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Bank image built from the write port as the bank would commit it.
  always @(posedge clk) if (we3 === 1'b1) obs_bank[wa3] <= wd3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = v[i];
      req_addr[i*AW +: AW]   = a[i];
      req_data[i*DW +: DW]   = d[i];
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_ptr = 0; m_we = 0; m_wa = '0; m_wd = '0; m_gid = 0; m_done = 0;
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;
  endtask

  // One clock: check ready before the edge, advance the model, check registered outputs after.
  task automatic cycle(output int gi);
    logic [NREQ-1:0] exp_rdy;
    bit was_run;
    bit was_clear;
    drive();
    #1;
    gi = -1;
    if (m_run && !clear)
      for (int k = 0; k < NREQ; k++)
        if (gi < 0 && v[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
    exp_rdy = '0;
    if (gi >= 0) exp_rdy[gi] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    was_run = m_run;
    was_clear = clear;
    @(posedge clk);
    #1;
    if (was_clear) begin
      m_run = 0; m_cnt = 0; m_done = 0; m_we = 0;
    end else if (!was_run) begin
      m_we = 1; m_wa = AW'(m_cnt); m_wd = '0;
      exp_bank[m_cnt] = '0;
      if (m_cnt == DEPTH - 1) begin m_run = 1; m_done = 1; end
      m_cnt = (m_cnt + 1) % DEPTH;
    end else if (gi >= 0) begin
      m_wa = a[gi]; m_wd = d[gi]; m_gid = gi;
      m_we = (a[gi] != 0);
      if (m_we) exp_bank[a[gi]] = d[gi];
      m_ptr = (gi + 1) % NREQ;
    end else begin
      m_we = 0;
    end
    chk("we3", we3, m_we);
    chk("wa3", wa3, m_wa);
    chk("wd3", wd3, m_wd);
    chk("grant_id", grant_id, m_gid);
    chk("init_done", init_done, m_done);
    for (int i = 0; i < NREQ; i++) begin
      if (!was_run || was_clear || !v[i]) waitc[i] = 0;
      else if (gi == i) begin
        chk("fair_wait", waitc[i], (waitc[i] <= NREQ - 1) ? waitc[i] : NREQ - 1);
        waitc[i] = 0;
      end else waitc[i]++;
    end
  endtask

  initial begin
    int gi;
    int n;
    for (int i = 0; i < NREQ; i++) begin v[i] = 0; a[i] = '0; d[i] = '0; end
    drive();
    model_reset();

    // Reset state
    #2;
    chk("rst_we3", we3, 1'b0);
    chk("rst_wa3", wa3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_done", init_done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: 32-edge zero sweep
    for (int k = 0; k < DEPTH; k++) begin
      cycle(gi);
      chk("t1_sweep_wa3", wa3, k);
      chk("t1_sweep_we3", we3, 1'b1);
    end
    chk("t1_done_at_31", init_done, 1'b1);
    cycle(gi);
    chk("t1_edge33_we3", we3, 1'b0);

    // Test 2: single requester
    v[2] = 1; a[2] = 5; d[2] = 32'hDEADBEEF;
    cycle(gi);
    chk("t2_gid", grant_id, 2);
    chk("t2_wd3", wd3, 32'hDEADBEEF);
    v[2] = 0;
    cycle(gi);
    chk("t2_bank5", obs_bank[5], 32'hDEADBEEF);

    // Move pointer to 0 via requester 3
    v[3] = 1; a[3] = 9; d[3] = 32'h99;
    cycle(gi);
    v[3] = 0;

    // Test 3: all requesters continuously valid
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1; a[i] = AW'(i + 1); d[i] = 32'h11 * (i + 1);
    end
    for (int k = 0; k < 5; k++) begin
      cycle(gi);
      chk("t3_gid_seq", grant_id, k % 4);
      chk("t3_wa3_seq", wa3, (k % 4) + 1);
      chk("t3_we3", we3, 1'b1);
    end
    for (int i = 0; i < NREQ; i++) v[i] = 0;

    // Test 4: write to r0 is accepted but suppressed
    v[1] = 1; a[1] = 0; d[1] = 32'hFFFFFFFF;
    cycle(gi);
    chk("t4_gid", grant_id, 1);
    chk("t4_we3", we3, 1'b0);
    v[1] = 0;
    v[2] = 1; a[2] = 10; d[2] = 32'h2222;
    cycle(gi);
    chk("t4_ptr_adv_gid", grant_id, 2);
    v[2] = 0;

    // Test 5: same-address collision with ptr=3
    v[0] = 1; a[0] = 7; d[0] = 32'hAAAA0000;
    v[3] = 1; a[3] = 7; d[3] = 32'h0000BBBB;
    cycle(gi);
    chk("t5_first_gid", grant_id, 3);
    chk("t5_first_wd3", wd3, 32'h0000BBBB);
    v[3] = 0;
    cycle(gi);
    chk("t5_second_gid", grant_id, 0);
    v[0] = 0;
    cycle(gi);
    chk("t5_bank7", obs_bank[7], 32'hAAAA0000);
    chk("t4_bank0", obs_bank[0], 32'h0);

    // Randomized traffic with occasional clear pulses
    for (n = 0; n < 400; n++) begin
      cycle(gi);
      clear = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (gi == i) begin
          v[i] = 1'($urandom_range(0, 1)); a[i] = AW'($urandom); d[i] = $urandom;
        end else if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1; a[i] = AW'($urandom); d[i] = $urandom;
        end
      end
    end
    clear = 0;
    for (int i = 0; i < NREQ; i++) v[i] = 0;
    for (int k = 0; k < DEPTH + 2; k++) cycle(gi);
    for (int r = 0; r < DEPTH; r++) chk("rand_bank", obs_bank[r], exp_bank[r]);

    // Test 6: clear mid-run with a pending request
    v[0] = 1; a[0] = 12; d[0] = 32'h0C0C0C0C;
    clear = 1;
    cycle(gi);
    chk("t6_done_fell", init_done, 1'b0);
    chk("t6_we3_off", we3, 1'b0);
    clear = 0;
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin
      cycle(gi);
      n++;
    end
    chk("t6_sweep_len", n, DEPTH);
    cycle(gi);
    chk("t6_pending_gid", grant_id, 0);
    chk("t6_pending_wa3", wa3, 12);
    v[0] = 0;

    // Reset mid-sweep
    clear = 1;
    cycle(gi);
    clear = 0;
    for (int k = 0; k < 10; k++) cycle(gi);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_we3", we3, 1'b0);
    chk("midrst_wa3", wa3, 0);
    chk("midrst_done", init_done, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(gi);
    chk("midrst_restart_wa3", wa3, 0);
    for (int k = 1; k < DEPTH + 1; k++) cycle(gi);
    for (int r = 0; r < DEPTH; r++) chk("final_bank_zero", obs_bank[r], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
